// File: rtl/mem_stream_ctrl.sv
// mem_stream_ctrl: turns one read/write command into single-port memory strobes and a valid/ready word stream
module mem_stream_ctrl #(
    parameter int word_len = 8,
    parameter int addr_len = 8,
    parameter int cnt_len  = addr_len + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [addr_len-1:0] base_addr,
    input  logic [cnt_len-1:0]  count,
    output logic                busy,
    output logic                done,
    output logic [word_len-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic [word_len-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [addr_len-1:0] mem_addr,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic [word_len-1:0] mem_wdata,
    input  logic [word_len-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, RD_OUT, WR_IN, WR_MEM, DONE} state_t;
    state_t state, state_nx;
    logic [addr_len-1:0] ptr;
    logic [cnt_len-1:0]  remaining;
    logic [word_len-1:0] dreg;
    logic                last;
    logic                step;
    assign last = remaining == cnt_len'(1);
    assign step = (state == RD_OUT && out_ready) || state == WR_MEM;
    // state register; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    // next-state: commands only accepted in IDLE, zero count completes immediately
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (count == '0) ? DONE : (mode ? WR_IN : RD_REQ);
            RD_REQ:  state_nx = RD_CAP;
            RD_CAP:  state_nx = RD_OUT;
            RD_OUT:  if (out_ready) state_nx = last ? DONE : RD_REQ;
            WR_IN:   if (in_valid) state_nx = WR_MEM;
            WR_MEM:  state_nx = last ? DONE : WR_IN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // pointer/count bookkeeping and the single data holding register shared by both directions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            remaining <= '0;
            dreg      <= '0;
        end else begin
            if (state == IDLE && start) begin
                ptr       <= base_addr;
                remaining <= count;
            end
            if (step) begin
                ptr       <= ptr + addr_len'(1);
                remaining <= remaining - cnt_len'(1);
            end
            if (state == RD_CAP) dreg <= mem_rdata;
            if (state == WR_IN && in_valid) dreg <= in_data;
        end
    end
    // outputs decoded from state and registers only, zero outside their owning state
    always_comb begin
        busy         = state != IDLE;
        done         = state == DONE;
        out_valid    = state == RD_OUT;
        out_data     = (state == RD_OUT) ? dreg : '0;
        in_ready     = state == WR_IN;
        mem_read_en  = state == RD_REQ;
        mem_write_en = state == WR_MEM;
        mem_addr     = (state == RD_REQ || state == WR_MEM) ? ptr : '0;
        mem_wdata    = (state == WR_MEM) ? dreg : '0;
    end
endmodule

// File: tb/tb_mem_stream_ctrl.sv
// tb_mem_stream_ctrl: directed and random command sequences against a word-array reference of the memory
module tb_mem_stream_ctrl;
    logic       clk = 0;
    logic       rst = 0;
    logic       start = 0, mode = 0;
    logic [7:0] base_addr = 0;
    logic [8:0] count = 0;
    logic       busy, done, out_valid, in_ready;
    logic       out_ready = 0, in_valid = 0;
    logic [7:0] out_data, mem_addr, mem_wdata, mem_rdata;
    logic [7:0] in_data = 0;
    logic       mem_read_en, mem_write_en;
    int checks = 0, errors = 0;
    int cyc = 0, n_rd = 0, n_wr = 0, n_done = 0;
    bit both_hi = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] mem [256];
    logic [7:0] wq [$];
    int r0, w0, d0;

    mem_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .mem_addr(mem_addr),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // single-port memory: read data appears the cycle after the read edge, both-high is a no-op
    always @(posedge clk) begin
        if (mem_write_en && !mem_read_en) mem[mem_addr] <= mem_wdata;
        if (mem_read_en && !mem_write_en) mem_rdata <= mem[mem_addr];
    end

    // strobe / done pulse counters sampled at the edge that acts on them
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_read_en) n_rd <= n_rd + 1;
        if (mem_write_en) n_wr <= n_wr + 1;
        if (done) n_done <= n_done + 1;
        if (mem_read_en && mem_write_en) both_hi <= 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk(tag, {busy, done, out_valid, in_ready, mem_read_en, mem_write_en, mem_addr, mem_wdata, out_data}, 0);
    endtask

    // stall >= 0: fixed idle cycles before each word; stall < 0: random 0..-stall
    task automatic wr_cmd(input logic [7:0] base, input int n, input int stall, input int abort_at);
        int t0, k;
        logic [7:0] a, d;
        start = 1; mode = 1; base_addr = base; count = n[8:0]; t0 = cyc;
        @(negedge clk);
        start = 0; base_addr = $urandom; count = 9'($urandom);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) return;
            a = base + i[7:0];
            if (wq.size() > 0) d = wq.pop_front();
            else d = 8'($urandom);
            k = (stall >= 0) ? stall : int'($urandom_range(-stall, 0));
            repeat (k) begin
                chk("wr_wait", {in_ready, mem_write_en}, 2'b10);
                @(negedge clk);
            end
            chk("wr_in", {busy, in_ready, out_valid, mem_write_en}, 4'b1100);
            in_valid = 1; in_data = d;
            @(negedge clk);
            in_valid = 0; in_data = $urandom;
            chk("wr_strobe", {mem_write_en, mem_read_en, in_ready}, 3'b100);
            chk("wr_addr", mem_addr, a);
            chk("wr_data", mem_wdata, d);
            ref_mem[a] = d;
            @(negedge clk);
        end
        chk("wr_done", {done, busy}, 2'b11);
        if (stall == 0) chk("wr_cycles", cyc - t0, 2 * n + 1);
        @(negedge clk);
        chk("wr_idle", {done, busy}, 2'b00);
    endtask

    task automatic rd_cmd(input logic [7:0] base, input int n, input int stall, input int abort_at, input bit poke);
        int t0, k;
        logic [7:0] a, e;
        start = 1; mode = 0; base_addr = base; count = n[8:0]; t0 = cyc;
        out_ready = (stall == 0);
        @(negedge clk);
        start = 0; base_addr = $urandom; count = 9'($urandom);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) return;
            a = base + i[7:0];
            e = ref_mem[a];
            chk("rd_req", {mem_read_en, mem_write_en, out_valid, busy}, 4'b1001);
            chk("rd_addr", mem_addr, a);
            @(negedge clk);
            chk("rd_cap", {mem_read_en, out_valid}, 2'b00);
            if (poke && i == 0) begin
                start = 1; mode = 1; base_addr = base + 8'h80; count = 9'd1;
            end
            @(negedge clk);
            start = 0; mode = 0;
            k = (stall >= 0) ? stall : int'($urandom_range(-stall, 0));
            repeat (k) begin
                chk("rd_stall", {out_valid, mem_read_en, out_data}, {2'b10, e});
                @(negedge clk);
            end
            chk("rd_out", {out_valid, mem_read_en, out_data}, {2'b10, e});
            out_ready = 1;
            @(negedge clk);
            out_ready = (stall == 0);
        end
        chk("rd_done", {done, busy, out_valid}, 3'b110);
        if (stall == 0) chk("rd_cycles", cyc - t0, 3 * n + 1);
        out_ready = 0;
        @(negedge clk);
        chk("rd_idle", {done, busy}, 2'b00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero_outs("reset_outs");
        rst = 1;
        @(negedge clk);
        chk_zero_outs("idle_outs");

        // fill the whole memory so every later read has a known reference
        wr_cmd(8'h00, 256, 0, -1);

        r0 = n_rd; w0 = n_wr; d0 = n_done;
        wq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        wr_cmd(8'h10, 4, 0, -1);
        rd_cmd(8'h10, 4, 0, -1, 0);
        chk("seq_wr_pulses", n_wr - w0, 4);
        chk("seq_rd_pulses", n_rd - r0, 4);
        chk("seq_done", n_done - d0, 2);
        chk("seq_word0", ref_mem[8'h10], 8'hA1);

        r0 = n_rd;
        rd_cmd(8'h10, 3, 5, -1, 0);
        chk("bp_rd_pulses", n_rd - r0, 3);

        r0 = n_rd; w0 = n_wr; d0 = n_done;
        wr_cmd(8'h33, 0, 0, -1);
        rd_cmd(8'h33, 0, 0, -1, 0);
        chk("zero_strobes", (n_rd - r0) + (n_wr - w0), 0);
        chk("zero_done", n_done - d0, 2);

        wr_cmd(8'hFF, 2, 0, -1);
        rd_cmd(8'hFE, 3, 0, -1, 0);

        w0 = n_wr; r0 = n_rd;
        rd_cmd(8'h20, 3, 0, -1, 1);
        repeat (2) @(negedge clk);
        chk("poke_no_write", n_wr - w0, 0);
        chk("poke_rd_pulses", n_rd - r0, 3);
        chk("poke_idle", busy, 0);

        d0 = n_done;
        wr_cmd(8'h50, 4, 0, 2);
        #2 rst = 0;
        #1 chk_zero_outs("rst_mid_wr");
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        chk_zero_outs("after_rst_wr");
        chk("rst_wr_no_done", n_done - d0, 0);
        rd_cmd(8'h50, 2, 0, -1, 0);

        d0 = n_done;
        rd_cmd(8'h50, 4, 0, 2, 0);
        #2 rst = 0;
        #1 chk_zero_outs("rst_mid_rd");
        out_ready = 0;
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        chk_zero_outs("after_rst_rd");
        chk("rst_rd_no_done", n_done - d0, 0);

        repeat (40) begin
            logic [7:0] b;
            int n, s;
            b = 8'($urandom);
            n = int'($urandom_range(6, 0));
            s = ($urandom_range(1, 0) == 1) ? 0 : -3;
            if ($urandom_range(1, 0) == 1) wr_cmd(b, n, s, -1);
            else rd_cmd(b, n, s, -1, 0);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        chk("strobe_exclusive", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
